// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns one load/store from the memory stage into a word-aligned
// valid/ready bus request and stalls the pipeline until it completes. Optional: MISALIGN_TRAP_EN.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              acc_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic                is_load_q, is_load_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rv_q, rv_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                start, f3_ok, misalign;
  logic [3:0]          be_new;
  logic [31:0]         wdata_new, load_ext;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;

  assign start = memread | memwrite;

  // Decode of the incoming request: legality, byte enables and lane-replicated store data.
  always_comb begin
    unique case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~memwrite;
      default:                f3_ok = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    unique case (funct3[1:0])
      2'b00:   begin be_new = 4'b0001 << addr[1:0];             wdata_new = {4{wdata[7:0]}};  end
      2'b01:   begin be_new = addr[1] ? 4'b1100 : 4'b0011;      wdata_new = {2{wdata[15:0]}}; end
      default: begin be_new = 4'b1111;                          wdata_new = wdata;            end
    endcase
  end

  // Load extraction uses the offset captured at accept time; halves follow addr[1] only.
  always_comb begin
    lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    f3_d      = f3_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rv_d      = 1'b0;
    err_d     = 1'b0;
    req_d     = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    stall     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          stall     = 1'b1;
          is_load_d = ~memwrite;
          f3_d      = funct3;
          off_d     = addr[1:0];
          cnt_d     = '0;
          if (f3_ok && !misalign) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = memwrite;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
          end else begin
            // Rejected accesses never touch the bus; they complete with an error.
            state_d = DONE;
            err_d   = 1'b1;
            rv_d    = ~memwrite;
            rdata_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        stall = 1'b1;
        req_d = 1'b1;
        if (bus_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          rv_d    = is_load_q;
          if (is_load_q) rdata_d = load_ext;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIM - CNT_W'(1))) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rv_d    = is_load_q;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign acc_err     = err_q;
  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a table of single accesses against a zero-wait memory,
// plus hand-written wait-state, timeout, back-to-back and reset sequences.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, acc_err, bus_req, bus_we, bus_ready;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .acc_err(acc_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] brd;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic        seen_req, done, exp_rv;
    logic [3:0]  be_s;
    logic [31:0] wd_s, ad_s;
    logic        we_s;
    exp_rv = v.rd & ~v.wr;
    seen_req = 1'b0; done = 1'b0;
    be_s = '0; wd_s = '0; ad_s = '0; we_s = 1'b0;
    @(negedge clk);
    memread = v.rd; memwrite = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wd;
    bus_rdata = v.brd; bus_ready = 1'b1;
    #1 check({nm, ".stall_accept"}, {31'h0, stall}, 32'd1);
    @(posedge clk);
    #1 memread = 1'b0; memwrite = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus_req && !seen_req) begin
        seen_req = 1'b1; be_s = bus_be; wd_s = bus_wdata; ad_s = bus_addr; we_s = bus_we;
      end
      if (!stall) begin
        done = 1'b1;
        check({nm, ".rdata_valid"}, {31'h0, rdata_valid}, {31'h0, exp_rv});
        check({nm, ".acc_err"}, {31'h0, acc_err}, {31'h0, v.exp_err});
        if (exp_rv || v.exp_err) check({nm, ".rdata"}, rdata, v.exp_rd);
      end
    end
    check({nm, ".completed"}, {31'h0, done}, 32'd1);
    check({nm, ".bus_req_seen"}, {31'h0, seen_req}, {31'h0, v.exp_req});
    if (v.exp_req) begin
      check({nm, ".bus_be"}, {28'h0, be_s}, {28'h0, v.exp_be});
      check({nm, ".bus_wdata"}, wd_s, v.exp_wd);
      check({nm, ".bus_addr"}, ad_s, {v.addr[31:2], 2'b00});
      check({nm, ".bus_we"}, {31'h0, we_s}, {31'h0, v.wr});
    end
    @(negedge clk);
    check({nm, ".pulse_end"}, {30'h0, rdata_valid, acc_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          stall_cnt, req_cnt;
    logic        done;
    //            rd    wr    f3      addr      wd            brd           req   be       exp_wd        err   exp_rd
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 1'b1, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 1'b1, 4'b1000, 32'h0,        1'b0, 32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80FF1234, 1'b1, 4'b1100, 32'h0,        1'b0, 32'hFFFF80FF};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h200, 32'h0,        32'h80FF1234, 1'b1, 4'b0011, 32'h0,        1'b0, 32'h00001234};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'h12345678, 1'b1, 4'b1111, 32'h0,        1'b0, 32'h12345678};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h300, 32'h1111ABCD, 32'h0,        1'b1, 4'b0011, 32'hABCDABCD, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h12,       32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b000, 32'h200, 32'h0,        32'h0000007F, 1'b1, 4'b0001, 32'h0,        1'b0, 32'h0000007F};
`ifdef MISALIGN_TRAP_EN
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'hCAFEF00D, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
`else
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'hCAFEF00D, 1'b1, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D};
`endif

    rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ctrl", {26'h0, stall, rdata_valid, acc_err, bus_req, bus_we, 1'b0}, 32'd0);
    check("reset.bus_be", {28'h0, bus_be}, 32'd0);
    check("reset.rdata", rdata, 32'd0);
    check("reset.bus_addr", bus_addr, 32'd0);
    check("reset.bus_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Store half with three wait cycles: request must hold steady, stall covers accept + 4 REQ cycles.
    @(negedge clk);
    memwrite = 1'b1; funct3 = 3'b001; addr = 32'h302; wdata = 32'h0000ABCD; bus_ready = 1'b0;
    #1 stall_cnt = stall ? 1 : 0;
    @(posedge clk);
    #1 memwrite = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        check("sh_wait.rdata_valid", {31'h0, rdata_valid}, 32'd0);
      end else begin
        stall_cnt++;
        check("sh_wait.bus_req", {31'h0, bus_req}, 32'd1);
        check("sh_wait.bus_be", {28'h0, bus_be}, 32'hC);
        check("sh_wait.bus_wdata", bus_wdata, 32'hABCDABCD);
        check("sh_wait.bus_addr", bus_addr, 32'h300);
        if (c == 3) bus_ready = 1'b1;
      end
    end
    check("sh_wait.completed", {31'h0, done}, 32'd1);
    check("sh_wait.stall_cycles", stall_cnt, 32'd5);
    bus_ready = 1'b0;

    // Load that is never answered: four REQ cycles, then an error completion.
    @(negedge clk);
    memread = 1'b1; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk);
    #1 memread = 1'b0;
    req_cnt = 0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (bus_req) req_cnt++;
      if (!stall) begin
        done = 1'b1;
        check("timeout.acc_err", {31'h0, acc_err}, 32'd1);
        check("timeout.rdata", rdata, 32'd0);
      end
    end
    check("timeout.completed", {31'h0, done}, 32'd1);
    check("timeout.req_cycles", req_cnt, 32'd4);
    @(negedge clk);
    check("timeout.pulse_end", {30'h0, acc_err, bus_req}, 32'd0);

    // Both strobes with illegal funct3 (store wins), then a load accepted in the DONE cycle.
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b1; funct3 = 3'b011; addr = 32'h100;
    bus_ready = 1'b1; bus_rdata = 32'h5555AAAA;
    @(posedge clk);
    #1 memwrite = 1'b0; funct3 = 3'b010;
    @(negedge clk);
    check("b2b.err_pulse", {31'h0, acc_err}, 32'd1);
    check("b2b.err_no_req", {31'h0, bus_req}, 32'd0);
    check("b2b.err_no_rv", {31'h0, rdata_valid}, 32'd0);
    check("b2b.stall_accept", {31'h0, stall}, 32'd1);
    @(posedge clk);
    #1 memread = 1'b0;
    @(negedge clk);
    check("b2b.bus_req", {31'h0, bus_req}, 32'd1);
    check("b2b.err_cleared", {31'h0, acc_err}, 32'd0);
    check("b2b.bus_addr", bus_addr, 32'h100);
    @(negedge clk);
    check("b2b.rdata_valid", {31'h0, rdata_valid}, 32'd1);
    check("b2b.rdata", rdata, 32'h5555AAAA);

    // Reset during REQ: bus_req drops at the reset edge, no completion afterwards.
    @(negedge clk);
    memread = 1'b1; funct3 = 3'b010; addr = 32'h140; bus_ready = 1'b0;
    @(posedge clk);
    #1 memread = 1'b0;
    @(negedge clk);
    check("rst_mid.bus_req_before", {31'h0, bus_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check("rst_mid.bus_req_after", {31'h0, bus_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_mid.quiet", {28'h0, stall, bus_req, rdata_valid, acc_err}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Responder side of the decode stage's memread/memwrite control signals. Takes one load or store from the memory stage, drives a word-aligned valid/ready request on the data-memory bus, and stalls the pipeline until the access completes. Generates byte enables and replicated store data. Extracts and sign/zero-extends load data. Sits between the memory-stage pipeline register and data memory.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in REQ waiting for bus_ready before abort; 0 disables timeout
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
memread  in  1  load request from pipeline control
memwrite  in  1  store request from pipeline control
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  hold pipeline; access in progress
rdata  out  32  extended load result, valid when rdata_valid
rdata_valid  out  1  one-cycle pulse at completion of a load
acc_err  out  1  one-cycle pulse: illegal funct3, misaligned (if enabled) or timeout
bus_req  out  1  bus request valid
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word address, bits [1:0] = 00
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ready  in  1  memory accepts/completes request this cycle
bus_rdata  in  32  read word, valid when bus_ready && !bus_we

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n). On reset: state IDLE; stall, rdata_valid, acc_err, bus_req, bus_we = 0; bus_be = 0; rdata, bus_addr, bus_wdata = 0.
- FSM states:
  - IDLE: if memread|memwrite, latch addr/funct3/wdata/op and go to REQ. stall = 1 combinationally in that same cycle.
  - REQ: bus_req = 1; bus_addr/bus_we/bus_be/bus_wdata are registered and must stay stable until bus_ready is sampled high. On bus_ready go to DONE.
  - DONE: stall = 0. For loads, rdata_valid = 1 with registered rdata. A new request in DONE is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Request priority: memwrite and memread both high → store; memread is ignored.
- Request capture: memread/memwrite are ignored while in REQ. The pipeline holds them because stall is high.
- Latency with a zero-wait memory (bus_ready high in the first REQ cycle): accept cycle N, bus_req in N+1, DONE/rdata_valid in N+2. Each wait cycle adds one.
- Byte enables:
  - B: 1 << addr[1:0].
  - H: 0011 if addr[1] = 0, else 1100.
  - W: 1111.
- Store data lanes: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes wdata through.
- Load extraction: select the byte/half by addr[1:0] from bus_rdata. B/H sign-extend; BU/HU zero-extend.
- Illegal funct3 (011, 110, 111; or 100/101 on a store): no bus request; go IDLE→DONE directly. acc_err pulses in DONE; rdata = 0; rdata_valid pulses if the op is a load.
- Timeout (TIMEOUT_CYCLES > 0): a counter clears on entry to REQ and increments each REQ cycle without bus_ready. On reaching TIMEOUT_CYCLES, drop bus_req and go to DONE with acc_err = 1 and rdata = 0. bus_ready in the same cycle as the limit wins (normal completion).
- Reset mid-access: the next edge with rst_n = 0 forces IDLE. bus_req falls that edge; no completion pulse.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an H at addr[0] = 1 or a W with addr[1:0] ≠ 00 is rejected. No bus request; path IDLE→DONE with acc_err pulse and rdata = 0.
- Undefined: misalignment is not checked. The low address bits are dropped. W uses bus_be = 1111. H uses the lane chosen by addr[1] only. Data is extracted from the aligned lanes. acc_err is never raised for alignment.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, bus_ready held 1 → bus_addr=0x104, bus_be=1111, bus_we=1, bus_wdata=0xDEADBEEF; stall high for 2 cycles, then 0; no rdata_valid.
- LB addr=0x203, bus_rdata=0x80FF1234 → bus_be=1000; rdata=0xFFFFFF80, rdata_valid pulse. LBU at the same address → rdata=0x00000080.
- SH addr=0x302, wdata=0x0000ABCD, bus_ready delayed 3 cycles → bus_be=1100, bus_wdata=0xABCDABCD; outputs stable across wait cycles; stall high for 5 cycles.
- TIMEOUT_CYCLES=4, LW, bus_ready never high → bus_req high exactly 4 cycles, then acc_err pulse, rdata=0, stall released.
- memread and memwrite both high, funct3=011 → no bus_req; acc_err pulse one cycle after accept. Then LW issued in the DONE cycle → accepted back-to-back.
- With MISALIGN_TRAP_EN, LW addr=0x102 → acc_err, no bus_req. Without it, the same access → bus_addr=0x100, bus_be=1111, rdata=bus_rdata. Reset asserted during REQ → bus_req low next edge.
